// File: rtl/log_lut_pkg.sv
// Shared widths, index/value types and search FSM encoding for the log-table
// inverse lookup.
package log_lut_pkg;
    localparam int U_WID        = 6;
    localparam int X_WID        = 16;
    localparam int NUM_SEGMENTS = 1 << U_WID;
    localparam int BIT_WID      = $clog2(U_WID + 1);

    typedef logic [U_WID-1:0]   lut_idx_t;
    typedef logic [X_WID-1:0]   lut_val_t;
    typedef logic [BIT_WID-1:0] bit_cnt_t;

    typedef enum logic [1:0] {IDLE, WAIT, CMP, DONE} search_state_t;

    // bit counter value U_WID marks the saturation probe of table[0]
    localparam bit_cnt_t FIRST_PROBE = bit_cnt_t'(U_WID);
    localparam lut_idx_t MSB_MASK    = lut_idx_t'(1) << (U_WID - 1);
endpackage

// File: rtl/log_lut_inverse.sv
// MSB-first binary search over the external registered log ROM: returns the
// largest index whose table entry is >= x, or a saturation flag.
module log_lut_inverse
    import log_lut_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  lut_val_t x_i,
    input  logic     x_valid_i,
    output logic     x_ready_o,
    output lut_idx_t u_o,
    output logic     sat_o,
    output logic     u_valid_o,
    input  logic     u_ready_i,
    output lut_idx_t rom_addr_o,
    input  lut_val_t rom_data_i
);
    search_state_t state;
    lut_val_t      x_reg;
    lut_idx_t      acc_reg;
    bit_cnt_t      bit_reg;

    logic     probe_ge;
    lut_idx_t acc_next;

    always_comb begin
        probe_ge = (rom_data_i >= x_reg);
        acc_next = acc_reg | (lut_idx_t'(probe_ge) << bit_reg);
    end

    assign x_ready_o = (state == IDLE) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            x_reg      <= '0;
            acc_reg    <= '0;
            bit_reg    <= '0;
            u_o        <= '0;
            sat_o      <= 1'b0;
            u_valid_o  <= 1'b0;
            rom_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (x_valid_i) begin
                        x_reg      <= x_i;
                        acc_reg    <= '0;
                        bit_reg    <= FIRST_PROBE;
                        rom_addr_o <= '0;
                        sat_o      <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: state <= CMP;
                CMP: begin
                    if (bit_reg == FIRST_PROBE) begin
                        // table[0] below x: nothing in the table reaches x
                        if (!probe_ge) begin
                            u_o       <= '0;
                            sat_o     <= 1'b1;
                            u_valid_o <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bit_reg    <= bit_cnt_t'(U_WID - 1);
                            rom_addr_o <= acc_reg | MSB_MASK;
                            state      <= WAIT;
                        end
                    end else begin
                        acc_reg <= acc_next;
                        if (bit_reg == '0) begin
                            u_o       <= acc_next;
                            sat_o     <= 1'b0;
                            u_valid_o <= 1'b1;
                            state     <= DONE;
                        end else begin
                            bit_reg    <= bit_reg - 1'b1;
                            rom_addr_o <= acc_next | (lut_idx_t'(1) << (bit_reg - 1'b1));
                            state      <= WAIT;
                        end
                    end
                end
                DONE: begin
                    if (u_ready_i) begin
                        u_valid_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
